// File: rtl/clockworks_gearbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clockworks_gearbox_pkg
//  Purpose  : Shared types and constants for the clock gearbox / reset generator
//  Revision : 1.0 - initial release
// ============================================================================
package clockworks_gearbox_pkg;

    localparam int unsigned c_hold_w = 8;

    typedef enum logic [0:0] {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } hold_state_t;

endpackage
`default_nettype wire

// File: rtl/clockworks_gearbox_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : clockworks_gearbox_sync_2ff
//  Purpose  : Two-flop level synchronizer with selectable power-up level
//  Revision : 1.0 - initial release
// ============================================================================
module clockworks_gearbox_sync_2ff #(
    parameter bit INIT = 1'b0
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    localparam int unsigned c_stages = 2;

    // Flops power up at 0; storing the level XORed with INIT makes the
    // observable power-up level equal to INIT without needing a reset.
    logic [c_stages-1:0] stage_raw;

    always_ff @(posedge clk) begin
        stage_raw <= {stage_raw[0], d ^ INIT};
    end

    assign q = stage_raw[c_stages-1] ^ INIT;

endmodule
`default_nettype wire

// File: rtl/clockworks_gearbox.sv
`default_nettype none
// ============================================================================
//  Module   : clockworks_gearbox
//  Purpose  : Power-of-two clock divider plus core reset generator that
//             releases resetn only on a falling edge of the divided clock
//  Revision : 1.0 - initial release
// ============================================================================
module clockworks_gearbox
    import clockworks_gearbox_pkg::*;
#(
    parameter int unsigned SLOW        = 0,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    localparam logic [c_hold_w-1:0] c_hold = c_hold_w'(HOLD_CYCLES);

    logic rise_tick;
    logic fall_tick;
    logic s2;

    generate
        if (SLOW == 0) begin : g_nodiv
            assign clk       = CLK;
            assign rise_tick = 1'b1;
            assign fall_tick = 1'b1;
        end else begin : g_div
            localparam logic [SLOW:0] c_rise_val = (SLOW + 1)'((1 << SLOW) - 1);

            // Free-running: never cleared, so the core keeps clocking in reset.
            logic [SLOW:0] div;

            always_ff @(posedge CLK) begin
                div <= div + (SLOW + 1)'(1);
            end

            assign clk       = div[SLOW];
            assign rise_tick = (div == c_rise_val);
            assign fall_tick = &div;
        end
    endgenerate

    clockworks_gearbox_sync_2ff #(
        .INIT (1'b1)
    ) u_reset_sync (
        .clk (CLK),
        .d   (RESET),
        .q   (s2)
    );

    hold_state_t         state;
    hold_state_t         state_nxt;
    logic [c_hold_w-1:0] hcnt;
    logic [c_hold_w-1:0] hcnt_nxt;

    always_ff @(posedge CLK) begin
        state <= state_nxt;
        hcnt  <= hcnt_nxt;
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        if (s2) begin
            state_nxt = S_HOLD;
            hcnt_nxt  = '0;
        end else if (state == S_HOLD) begin
            // Count slow-clock rises, then release on the following fall.
            if (hcnt < c_hold) begin
                if (rise_tick) begin
                    hcnt_nxt = hcnt + c_hold_w'(1);
                end
            end else if ((hcnt == c_hold) && fall_tick) begin
                state_nxt = S_RUN;
            end
        end
    end

    assign resetn = (state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_clockworks_gearbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clockworks_gearbox
//  Purpose  : Self-checking bench for clockworks_gearbox (SLOW=2 and SLOW=0)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clockworks_gearbox;

    localparam int H    = 4;
    localparam int MAXE = 8192;

    logic CLK  = 1'b0;
    logic rst2 = 1'b0;
    logic rst0 = 1'b0;
    logic clk2, clk0, rn2, rn0;

    int n_checks = 0;
    int n_fail   = 0;

    clockworks_gearbox #(.SLOW(2), .HOLD_CYCLES(H)) dut2 (
        .CLK    (CLK),
        .RESET  (rst2),
        .clk    (clk2),
        .resetn (rn2)
    );

    clockworks_gearbox #(.SLOW(0), .HOLD_CYCLES(H)) dut0 (
        .CLK    (CLK),
        .RESET  (rst0),
        .clk    (clk0),
        .resetn (rn0)
    );

    always #5 CLK = ~CLK;

    // Reference model: e counts CLK edges since power-up; RESET seen at edge k
    // is acted on at edge k+2; edges 1 and 2 act as reset (power-up hold).
    int e     = 0;
    int last2 = 0;
    int last0 = 0;
    bit hist2 [MAXE];
    bit hist0 [MAXE];

    always @(posedge CLK) begin
        e = e + 1;
        if (e < MAXE) begin
            hist2[e] = rst2;
            hist0[e] = rst0;
        end
        if (e <= 2) begin
            last2 = e;
            last0 = e;
        end else if (e < MAXE) begin
            if (hist2[e-2]) last2 = e;
            if (hist0[e-2]) last0 = e;
        end
    end

    // Edge at which resetn rises if the last reset-active edge was L.
    function automatic int release_edge(input int L, input int slow);
        int p, half, r1;
        if (slow == 0) return L + H + 1;
        p    = 1 << (slow + 1);
        half = p / 2;
        r1   = L + 1 + ((half - ((L + 1) % p) + p) % p);
        return r1 + p * (H - 1) + half;
    endfunction

    function automatic logic exp_rn2();
        return logic'(e >= release_edge(last2, 2));
    endfunction

    function automatic logic exp_rn0();
        return logic'(e >= release_edge(last0, 0));
    endfunction

    function automatic logic exp_clk2();
        return logic'((e % 8) >= 4);
    endfunction

    task automatic test_reset();
        #1;
        n_checks += 3;
        if (rn2 !== 1'b0) begin n_fail++; $display("FAIL reset_rn2 got %b expected 0", rn2); end
        if (clk2 !== 1'b0) begin n_fail++; $display("FAIL reset_clk2 got %b expected 0", clk2); end
        if (rn0 !== 1'b0) begin n_fail++; $display("FAIL reset_rn0 got %b expected 0", rn0); end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            n_checks += 3;
            if (clk2 !== exp_clk2()) begin n_fail++; $display("FAIL pwrup_clk2 e=%0d got %b expected %b", e, clk2, exp_clk2()); end
            if (rn2 !== exp_rn2()) begin n_fail++; $display("FAIL pwrup_rn2 e=%0d got %b expected %b", e, rn2, exp_rn2()); end
            if (rn0 !== exp_rn0()) begin n_fail++; $display("FAIL pwrup_rn0 e=%0d got %b expected %b", e, rn0, exp_rn0()); end
        end
    endtask

    task automatic test_pulse();
        int off;
        off = int'($urandom_range(0, 7));
        for (int i = 0; i < off + 60; i++) begin
            @(negedge CLK);
            n_checks += 2;
            if (clk2 !== exp_clk2()) begin n_fail++; $display("FAIL pulse_clk2 e=%0d got %b expected %b", e, clk2, exp_clk2()); end
            if (rn2 !== exp_rn2()) begin n_fail++; $display("FAIL pulse_rn2 e=%0d got %b expected %b", e, rn2, exp_rn2()); end
            rst2 = (i == off);
        end
        rst2 = 1'b0;
    endtask

    task automatic test_long_hold();
        for (int i = 0; i < 160; i++) begin
            @(negedge CLK);
            n_checks += 2;
            if (clk2 !== exp_clk2()) begin n_fail++; $display("FAIL long_clk2 e=%0d got %b expected %b", e, clk2, exp_clk2()); end
            if (rn2 !== exp_rn2()) begin n_fail++; $display("FAIL long_rn2 e=%0d got %b expected %b", e, rn2, exp_rn2()); end
            rst2 = (i < 100);
        end
        rst2 = 1'b0;
    endtask

    task automatic test_reassert();
        int k, len;
        k   = int'($urandom_range(14, 20));
        len = int'($urandom_range(1, 3));
        for (int i = 0; i < k + len + 60; i++) begin
            @(negedge CLK);
            n_checks += 2;
            if (clk2 !== exp_clk2()) begin n_fail++; $display("FAIL reassert_clk2 e=%0d got %b expected %b", e, clk2, exp_clk2()); end
            if (rn2 !== exp_rn2()) begin n_fail++; $display("FAIL reassert_rn2 e=%0d got %b expected %b", e, rn2, exp_rn2()); end
            rst2 = (i == 0) || (i >= k && i < k + len);
        end
        rst2 = 1'b0;
    endtask

    task automatic test_slow0();
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            n_checks++;
            if (clk0 !== 1'b1) begin n_fail++; $display("FAIL slow0_clk_high e=%0d got %b expected 1", e, clk0); end
            @(negedge CLK);
            n_checks += 2;
            if (clk0 !== 1'b0) begin n_fail++; $display("FAIL slow0_clk_low e=%0d got %b expected 0", e, clk0); end
            if (rn0 !== exp_rn0()) begin n_fail++; $display("FAIL slow0_rn0 e=%0d got %b expected %b", e, rn0, exp_rn0()); end
            rst0 = ($urandom_range(0, 24) == 0);
        end
        rst0 = 1'b0;
    endtask

    task automatic test_random_rise_stable();
        logic prev_clk, prev_rn;
        prev_clk = clk2;
        prev_rn  = rn2;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            n_checks += 4;
            if (clk2 !== exp_clk2()) begin n_fail++; $display("FAIL rand_clk2 e=%0d got %b expected %b", e, clk2, exp_clk2()); end
            if (rn2 !== exp_rn2()) begin n_fail++; $display("FAIL rand_rn2 e=%0d got %b expected %b", e, rn2, exp_rn2()); end
            if (rn0 !== exp_rn0()) begin n_fail++; $display("FAIL rand_rn0 e=%0d got %b expected %b", e, rn0, exp_rn0()); end
            if (prev_clk == 1'b0 && clk2 == 1'b1 && rn2 !== prev_rn) begin
                n_fail++;
                $display("FAIL rise_stable e=%0d got %b expected %b", e, rn2, prev_rn);
            end
            prev_clk = clk2;
            prev_rn  = rn2;
            rst2 = ($urandom_range(0, 59) == 0);
            rst0 = ($urandom_range(0, 29) == 0);
        end
        rst2 = 1'b0;
        rst0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_long_hold();
        test_reassert();
        test_slow0();
        test_random_rise_stable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
